udma_tx_req_arbiter: RTL
========================

# udma_tx_req_arbiter

Round-robin scheduler that shares one L2 read port among N_CH uDMA TX channels. Each channel's dual-clock TX FIFO raises a prefetch request, and the arbiter forwards one request per cycle to L2. It records the owning channel of every outstanding read, then steers each in-order read response back to that channel's FIFO write port. It sits in the uDMA core between the per-channel TX FIFOs and the L2 interconnect, entirely in the src_clk_i domain.

## Interface
- N_CH, 4: number of TX channels, 2..16.
- ADDR_WIDTH, 32: L2 address width.
- DATA_WIDTH, 32: read data width.
- MAX_OUTSTANDING, 4: outstanding L2 reads tracked, power of 2, ≥2.
- src_clk_i  in  1  clock; all logic is synchronous to it.
- rstn_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of the round-robin pointer and error flag.
- ch_req_i  in  N_CH  per-channel read request, held until granted.
- ch_addr_i  in  N_CH*ADDR_WIDTH  per-channel request address; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- ch_gnt_o  out  N_CH  per-channel grant, one-hot or zero.
- ch_valid_o  out  N_CH  per-channel response valid, one-hot or zero.
- ch_data_o  out  DATA_WIDTH  response data, broadcast to all channels.
- l2_req_o  out  1  L2 read request.
- l2_addr_o  out  ADDR_WIDTH  L2 read address.
- l2_gnt_i  in  1  L2 grant.
- l2_rvalid_i  in  1  L2 read response valid; responses return in grant order.
- l2_rdata_i  in  DATA_WIDTH  L2 read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count.
- err_o  out  1  sticky error: response received with nothing outstanding.

## Operation
- **Arbitration (combinational):**
  - Eligible channels: `ch_req_i & ~{N_CH{clr_i}}`.
  - Winner `sel`: first eligible channel at or after `rr_ptr`, scanning upward with wrap.
- **L2 request:**
  - `l2_req_o = |eligible & ~id_full`.
  - `l2_addr_o = ch_addr_i[sel]`; it is 0 when `l2_req_o` is low.
- **Channel grant:** `ch_gnt_o[sel] = l2_req_o & l2_gnt_i`; all other bits are 0.
- **Accepted request:**
  - An accepted request is `l2_req_o & l2_gnt_i`.
  - On acceptance, `rr_ptr <= (sel == N_CH-1) ? 0 : sel+1`, and `sel` is pushed into the ID FIFO.
- **ID FIFO:**
  - Depth MAX_OUTSTANDING, entry width $clog2(N_CH).
  - `id_full` when count == MAX_OUTSTANDING.
  - Push on accept and pop on `l2_rvalid_i` in the same cycle are both legal; the count is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- **Response routing:**
  - On `l2_rvalid_i` with count > 0: `ch_valid_o[id_head] = 1` and the FIFO pops.
  - `ch_data_o = l2_rdata_i` at all times.
- **Response with count == 0:**
  - `ch_valid_o` stays 0, nothing is popped, and `err_o` is set.
  - `err_o` clears only on reset or `clr_i`.
- **clr_i:**
  - Sets `rr_ptr` to 0 and masks new requests.
  - Does not flush the ID FIFO, so responses still in flight are routed correctly.
- **Channel obligation:** each channel must only request when it has FIFO space for the response. The arbiter applies no backpressure on responses.

## Timing
- **Reset values:**
  - `rr_ptr` = 0, ID FIFO empty.
  - Outputs: `outstanding_o` = 0, `err_o` = 0.
  - `l2_req_o`, `ch_gnt_o` and `ch_valid_o` are 0 for as long as the inputs are idle.
- **Request path:** zero-cycle combinational path from `ch_req_i` to `l2_req_o`, and from `l2_gnt_i` to `ch_gnt_o`.
- **Throughput:** one grant per cycle.
- **Response path:** zero-cycle path from `l2_rvalid_i` to `ch_valid_o`.
- **Fairness:** with all N_CH channels requesting continuously, each channel is granted exactly once every N_CH accepted requests.
- **Full ID FIFO with a simultaneous response:** `l2_req_o` stays 0 in that cycle. It is registered-count based, with no combinational path from `l2_rvalid_i` to `l2_req_o`.
- **Mid-operation reset:** asserting `rstn_i` discards all outstanding IDs. Any later stray response sets `err_o`.

## Configuration
- **Macro:** `UDMA_TX_ARB_PRIO_EN`.
- **Defined:**
  - Adds port `ch_prio_i  in  N_CH  high-priority mask`.
  - If any eligible channel has `ch_prio_i` set, round-robin runs over that subset only; otherwise it runs over all eligible channels.
  - `rr_ptr` is shared between the two levels.
- **Undefined:** the port is absent and plain round-robin applies.

## Test plan
- **Reset and idle:**
  - Stimulus: `rstn_i` low, then high, with all inputs 0.
  - Required: `l2_req_o` = 0, `ch_gnt_o` = 0, `outstanding_o` = 0, `err_o` = 0.
- **Fairness:**
  - Stimulus: N_CH = 4, `ch_req_i` = 4'b1111 held, `l2_gnt_i` = 1 every cycle.
  - Required: grant sequence is ch0, ch1, ch2, ch3, ch0…; `l2_addr_o` matches the granted channel's address each cycle.
- **Outstanding limit:**
  - Stimulus: MAX_OUTSTANDING = 4, continuous grants, no responses.
  - Required: 4 grants, then `l2_req_o` = 0 and `outstanding_o` = 4.
  - Stimulus: one response arrives.
  - Required: count drops to 3 and a grant is issued on the next cycle.
- **Response routing:**
  - Stimulus: grants to ch2, ch0, ch2; three responses with data 0xA, 0xB, 0xC.
  - Required: `ch_valid_o` = 4'b0100, 4'b0001, 4'b0100 in that order, with matching data.
- **Simultaneous push/pop and error:**
  - Stimulus: accept and `l2_rvalid_i` in the same cycle at count 2.
  - Required: count stays 2.
  - Stimulus: a response arrives at count 0.
  - Required: `err_o` = 1 and stays 1 until `clr_i`.
- **Priority (`UDMA_TX_ARB_PRIO_EN`):**
  - Stimulus: `ch_req_i` = 4'b1111, `ch_prio_i` = 4'b0100.
  - Required: ch2 is granted every cycle.
  - Stimulus: `ch_prio_i` = 0.
  - Required: round-robin resumes from ch3.

Source files
------------

// File: rtl/udma_tx_req_arbiter.sv
// Round-robin arbiter that shares one L2 read port among N_CH uDMA TX channels and
// routes in-order read responses back to their owners. Optional priority level: UDMA_TX_ARB_PRIO_EN.
module udma_tx_req_arbiter #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  src_clk_i,
    input  logic                                  rstn_i,
    input  logic                                  clr_i,
    input  logic [N_CH-1:0]                       ch_req_i,
    input  logic [N_CH*ADDR_WIDTH-1:0]            ch_addr_i,
`ifdef UDMA_TX_ARB_PRIO_EN
    input  logic [N_CH-1:0]                       ch_prio_i,
`endif
    output logic [N_CH-1:0]                       ch_gnt_o,
    output logic [N_CH-1:0]                       ch_valid_o,
    output logic [DATA_WIDTH-1:0]                 ch_data_o,
    output logic                                  l2_req_o,
    output logic [ADDR_WIDTH-1:0]                 l2_addr_o,
    input  logic                                  l2_gnt_i,
    input  logic                                  l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 l2_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic                                  err_o
);

    localparam int unsigned IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW  = PW + 1;

    logic [IDW-1:0] rr_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           err_q;
    logic [IDW-1:0] id_mem [MAX_OUTSTANDING];

    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] pool;
    logic [IDW-1:0]  sel;
    logic            found;
    logic [IDW:0]    idx_w;
    logic            id_full;
    logic            accept;
    logic            pop;
    logic            stray;

    // Scan upward from rr_ptr with wrap; first channel in the active pool wins.
    always_comb begin
        eligible = ch_req_i & ~{N_CH{clr_i}};
        pool     = eligible;
`ifdef UDMA_TX_ARB_PRIO_EN
        if ((eligible & ch_prio_i) != '0) begin
            pool = eligible & ch_prio_i;
        end
`endif
        sel   = '0;
        found = 1'b0;
        idx_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (idx_w >= (IDW+1)'(N_CH)) begin
                idx_w = idx_w - (IDW+1)'(N_CH);
            end
            if (!found && pool[idx_w[IDW-1:0]]) begin
                sel   = idx_w[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    // Full check uses the registered count only, so a same-cycle response cannot unblock.
    assign id_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign l2_req_o = (|eligible) && !id_full;
    assign accept   = l2_req_o && l2_gnt_i;
    assign pop      = l2_rvalid_i && (count_q != '0);
    assign stray    = l2_rvalid_i && (count_q == '0);

    always_comb begin
        ch_gnt_o   = '0;
        ch_valid_o = '0;
        l2_addr_o  = '0;
        if (accept) begin
            ch_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            ch_valid_o[id_mem[rd_ptr_q]] = 1'b1;
        end
        if (l2_req_o) begin
            l2_addr_o = ch_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign ch_data_o     = l2_rdata_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_ff @(posedge src_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (clr_i) begin
                rr_ptr_q <= '0;
            end else if (accept) begin
                rr_ptr_q <= (sel == IDW'(N_CH-1)) ? '0 : sel + 1'b1;
            end
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A stray response in the same cycle as clr_i is still reported.
            err_q <= stray || (err_q && !clr_i);
        end
    end

    // ID storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge src_clk_i) begin
        if (accept) begin
            id_mem[wr_ptr_q] <= sel;
        end
    end

endmodule
